axis_ovs_arbiter: RTL
=====================

# axis_ovs_arbiter

Round-robin, frame-aware arbiter that shares one oversampler input stream (`axis_1bit`, 4 samples per symbol) between two sample sources. It sits in front of the oversampler/correlator chain and hands ownership over only at symbol-group boundaries, so a 4-sample group is never split between sources. It also enforces a maximum frame length: a runaway frame is truncated with a forced end-of-frame symbol.

## Interface
Parameters:
- `MAX_SYMBOLS`, default 64: complete 4-sample groups a grant may hold before forced truncation; must be ≥1.

Ports:
- `i_clk`, input, 1: clock; all logic on the rising edge.
- `i_rst_n`, input, 1: reset; asynchronous, active-low.
- `s0_axis`, slave, axis_1bit: sample source 0.
- `s1_axis`, slave, axis_1bit: sample source 1.
- `m_axis`, master, axis_1bit: stream to the oversampler.
- `i_mask`, input, 2: bit k = 1 excludes source k from new grants; does not revoke a current grant.
- `o_grant`, output, 2: one-hot current owner; 2'b00 in IDLE.
- `o_trunc`, output, 1: one-cycle pulse when a truncated frame's final beat is accepted.

## Operation
- States: IDLE, BUSY, TRUNC.
- Beat: an accepted transfer (`m_axis.tvalid & m_axis.tready`).
- Group counters:
  - `phase`: 2 bits, counts beats within a group.
  - `last_cnt`: 3 bits, counts tlast=1 beats in the current group.
  - `sym_cnt`: `$clog2(MAX_SYMBOLS+1)` bits, counts completed groups.
  - All three clear on every entry to BUSY.
- IDLE:
  - Requester k is eligible when `sk_axis.tvalid=1` and `i_mask[k]=0`.
  - One eligible requester: grant it.
  - Both eligible: grant the source that was not granted last.
  - The last-granted register resets to 1, so source 0 wins the first tie.
  - A grant moves to BUSY on the next edge and sets `o_grant`.
- BUSY, data path (combinational):
  - `m_axis.tdata`, `m_axis.tlast`, `m_axis.tvalid` are copied from the granted source.
  - Granted `tready = m_axis.tready`; non-granted `tready = 0`.
- BUSY, on each beat:
  - `phase` increments.
  - `last_cnt` increments if tlast=1.
- BUSY, on a beat with `phase==3` (group complete):
  - `last_cnt`+current tlast ≥3 (majority end of frame): → IDLE.
  - Otherwise `sym_cnt` increments.
  - If `sym_cnt` reaches `MAX_SYMBOLS`: → TRUNC. Else stay in BUSY.
  - Clear `phase` and `last_cnt`.
- TRUNC:
  - Same pass-through as BUSY, except `m_axis.tlast` is forced to 1 on all 4 beats of one group.
  - After the 4th beat: → IDLE, and `o_trunc` pulses in the cycle after that beat.
  - Source tlast values are ignored in this state.
- IDLE → IDLE: no eligible requester.
- `m_axis.tuser` is always 0.
- Masking during BUSY/TRUNC has no effect until the grant is released.

## Timing
- Reset values (held while `i_rst_n=0`, applied asynchronously):
  - state=IDLE, last-granted=1, all counters 0.
  - `o_grant=0`, `o_trunc=0`.
  - `m_axis.tvalid/tdata/tlast=0`, both source tready=0.
- Reset mid-frame: the stream aborts immediately, with no forced tlast. After release, arbitration restarts from IDLE with source 0 preferred.
- Grant latency:
  - Requester eligible in IDLE cycle N → `o_grant` set and pass-through active in cycle N+1.
  - The first beat can transfer in N+1.
- Release bubble: after the closing beat at edge M, cycle M+1 is IDLE with no transfers. The earliest next grant is M+2, even if the other source is already waiting.
- AXIS rules on `m_axis`:
  - tvalid and data are held while tready=0, inherited from a compliant source.
  - The arbiter never changes ownership while a granted tvalid is pending without a beat, because release happens only on a beat.
- Simultaneous `phase==3` end-of-frame and `sym_cnt` limit: end-of-frame wins, → IDLE, no truncation.
- Counter `sym_cnt` saturates structurally: it never exceeds `MAX_SYMBOLS`.

## Test plan
- Single source: s0 sends 3 groups, tlast=1 on beats 8–11, `m_axis.tready=1`.
  - `o_grant` is 01 one cycle after s0 tvalid.
  - 12 beats pass unchanged.
  - IDLE after beat 11; s1 tready stays 0 throughout.
- Tie, round-robin: s0 and s1 each hold 2-group frames and request continuously.
  - Grants alternate 01,10,01,10, starting with 01.
  - Exactly one IDLE cycle between grants.
- Truncation: `MAX_SYMBOLS=4`, s1 streams with tlast=0 forever.
  - After 16 beats, the next 4 output beats have tlast=1.
  - `o_trunc` pulses once; then IDLE.
  - s0, if waiting, is granted next.
- Backpressure: toggle `m_axis.tready` randomly during a 5-group s0 frame.
  - Output beat sequence equals the input sequence.
  - No beat lost or duplicated; s0 tready mirrors `m_axis.tready` while granted.
- Mask/minority tlast: `i_mask=2'b01` with both requesting → s1 granted. In a group with tlast pattern 1,1,0,0 (2 of 4), no release occurs and the grant continues.
- Async reset mid-frame: assert `i_rst_n=0` between clock edges during beat 5.
  - `m_axis.tvalid` and `o_grant` go to 0 without waiting for an edge.
  - After release, a tie grants s0.

Source files
------------

// File: rtl/axis_ovs_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_ovs_arbiter
// Purpose  : Frame-aware round-robin arbiter that shares one 1-bit AXI-Stream
//            oversampler input between two sample sources. Ownership changes
//            only on 4-sample symbol-group boundaries, and a frame that
//            exceeds MAX_SYMBOLS groups is cut short by one extra group
//            carrying a forced tlast.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk            : clock, rising edge
//   i_rst_n          : asynchronous active-low reset
//   s0_axis_*        : sample source 0 (tdata, tvalid, tlast in / tready out)
//   s1_axis_*        : sample source 1 (tdata, tvalid, tlast in / tready out)
//   m_axis_*         : stream to the oversampler (tdata, tvalid, tlast,
//                      tuser out / tready in)
//   i_mask[1:0]      : bit k excludes source k from new grants
//   o_grant[1:0]     : one-hot current owner, 2'b00 while idle
//   o_trunc          : one-cycle pulse after a truncated frame's last beat
// Parameters
//   MAX_SYMBOLS      : complete groups a grant may hold before truncation
//                      (must be at least 1)
// ============================================================================
module axis_ovs_arbiter #(
    parameter int MAX_SYMBOLS = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,

    input  logic       s0_axis_tdata,
    input  logic       s0_axis_tvalid,
    input  logic       s0_axis_tlast,
    output logic       s0_axis_tready,

    input  logic       s1_axis_tdata,
    input  logic       s1_axis_tvalid,
    input  logic       s1_axis_tlast,
    output logic       s1_axis_tready,

    output logic       m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    input  logic       m_axis_tready,

    input  logic [1:0] i_mask,
    output logic [1:0] o_grant,
    output logic       o_trunc
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Wide enough to hold MAX_SYMBOLS itself, so the counter can sit at the
    // limit while the truncation group is sent.
    localparam int SYM_W = $clog2(MAX_SYMBOLS + 1);

    localparam logic [SYM_W-1:0] c_MAX_SYM = SYM_W'(MAX_SYMBOLS);
    localparam logic [SYM_W-1:0] c_SYM_ONE = SYM_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BUSY  = 2'd1;
    localparam logic [1:0] c_ST_TRUNC = 2'd2;

    localparam logic [1:0] c_PHASE_LAST = 2'd3;
    localparam logic [2:0] c_LAST_MAJ   = 3'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    // Doubles as the current owner while active and as the "last granted"
    // memory for round-robin tie breaking while idle.
    logic             r_owner;
    logic [1:0]       r_phase;
    logic [2:0]       r_last_cnt;
    logic [SYM_W-1:0] r_sym_cnt;
    logic             r_trunc;

    // ------------------------------------------------------------------------
    // Combinational selection of the owning source
    // ------------------------------------------------------------------------
    logic             w_active;
    logic             w_in_trunc;
    logic             w_src_valid;
    logic             w_src_data;
    logic             w_src_last;
    logic             w_beat;
    logic [1:0]       w_elig;
    logic             w_pick;
    logic [2:0]       w_last_total;
    logic [SYM_W-1:0] w_sym_next;
    logic             w_group_done;

    assign w_active   = (r_state != c_ST_IDLE);
    assign w_in_trunc = (r_state == c_ST_TRUNC);

    assign w_src_valid = r_owner ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_src_data  = r_owner ? s1_axis_tdata  : s0_axis_tdata;
    assign w_src_last  = r_owner ? s1_axis_tlast  : s0_axis_tlast;

    // Everything is gated by w_active, so the stream collapses to zero the
    // instant reset drops the state back to IDLE, without waiting for a clock.
    assign m_axis_tvalid = w_active & w_src_valid;
    assign m_axis_tdata  = w_active & w_src_data;
    assign m_axis_tlast  = w_active & (w_in_trunc | w_src_last);
    assign m_axis_tuser  = 1'b0;

    assign s0_axis_tready = w_active & ~r_owner & m_axis_tready;
    assign s1_axis_tready = w_active &  r_owner & m_axis_tready;

    assign o_grant = {w_active & r_owner, w_active & ~r_owner};
    assign o_trunc = r_trunc;

    assign w_beat       = m_axis_tvalid & m_axis_tready;
    assign w_group_done = w_beat & (r_phase == c_PHASE_LAST);

    // ------------------------------------------------------------------------
    // Arbitration: a lone eligible source wins outright; on a tie the source
    // that did not hold the previous grant wins.
    // ------------------------------------------------------------------------
    assign w_elig = {s1_axis_tvalid & ~i_mask[1], s0_axis_tvalid & ~i_mask[0]};
    assign w_pick = (&w_elig) ? ~r_owner : w_elig[1];

    // tlast count for the group including the beat being accepted now; the
    // group ends the frame when at least 3 of its 4 samples carry tlast.
    assign w_last_total = r_last_cnt + {2'b00, w_src_last};
    assign w_sym_next   = r_sym_cnt + c_SYM_ONE;

    // ------------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= c_ST_IDLE;
            r_owner    <= 1'b1;
            r_phase    <= 2'd0;
            r_last_cnt <= 3'd0;
            r_sym_cnt  <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_elig) begin
                        r_state    <= c_ST_BUSY;
                        r_owner    <= w_pick;
                        r_phase    <= 2'd0;
                        r_last_cnt <= 3'd0;
                        r_sym_cnt  <= '0;
                    end
                end

                c_ST_BUSY: begin
                    if (w_group_done) begin
                        r_phase    <= 2'd0;
                        r_last_cnt <= 3'd0;
                        // End of frame takes priority over the symbol limit,
                        // so a frame closing exactly at the limit is not
                        // truncated.
                        if (w_last_total >= c_LAST_MAJ) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_sym_cnt <= w_sym_next;
                            if (w_sym_next == c_MAX_SYM) begin
                                r_state <= c_ST_TRUNC;
                            end
                        end
                    end else if (w_beat) begin
                        r_phase    <= r_phase + 2'd1;
                        r_last_cnt <= w_last_total;
                    end
                end

                c_ST_TRUNC: begin
                    // One full group with tlast forced; source tlast is
                    // ignored and the counter stays parked at the limit.
                    if (w_group_done) begin
                        r_state <= c_ST_IDLE;
                        r_phase <= 2'd0;
                        r_trunc <= 1'b1;
                    end else if (w_beat) begin
                        r_phase <= r_phase + 2'd1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
